// File: rtl/arm_pipe_pkg.sv
// Shared definitions for the ARM pipeline hazard logic: sequencer state
// encoding, forwarding select codes and the PC register index.
package arm_pipe_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LD_STALL = 2'd1,
    MEM_WAIT = 2'd2
  } hz_state_t;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_EX  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b11;

  // R15 is the PC; it never creates a hazard and is never forwarded.
  localparam logic [3:0] PC_REG = 4'hF;

endpackage

// File: rtl/arm_fwd_select.sv
// Per-operand forwarding select: picks the youngest in-flight producer of
// the source register (EX, then MEM, then WB), else the register file.
module arm_fwd_select
  import arm_pipe_pkg::*;
#(
  parameter int REG_W = 4
) (
  input  logic [REG_W-1:0] src,
  input  logic             used,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_fwd_ok,
  input  logic [REG_W-1:0] mem_rd,
  input  logic             mem_reg_write,
  input  logic [REG_W-1:0] wb_rd,
  input  logic             wb_reg_write,
  output logic [1:0]       sel
);

  localparam logic [REG_W-1:0] PC_IDX = REG_W'(PC_REG);

  logic live;

  assign live = used && (src != PC_IDX);

  // Priority chain: the youngest producer wins.
  always_comb begin
    sel = FWD_RF;
    if (live && ex_fwd_ok && (ex_rd == src)) begin
      sel = FWD_EX;
    end else if (live && mem_reg_write && (mem_rd == src)) begin
      sel = FWD_MEM;
    end else if (live && wb_reg_write && (wb_rd == src)) begin
      sel = FWD_WB;
    end
  end

endmodule

// File: rtl/arm_hazard_controller.sv
// Hazard and stall sequencer for the 5-stage ARM pipeline: load-use stall,
// branch flush, data-memory freeze, operand forwarding and a saturating
// stall-cycle counter.
module arm_hazard_controller
  import arm_pipe_pkg::*;
#(
  parameter int REG_W = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [REG_W-1:0] id_rn,
  input  logic [REG_W-1:0] id_rm,
  input  logic [REG_W-1:0] id_rs,
  input  logic [2:0]       id_use,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_reg_write,
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] mem_rd,
  input  logic             mem_reg_write,
  input  logic [REG_W-1:0] wb_rd,
  input  logic             wb_reg_write,
  input  logic             ex_branch_taken,
  input  logic             mem_busy,
  output logic             pc_enable,
  output logic             if_id_enable,
  output logic             if_id_flush,
  output logic             nop_insert,
  output logic             pipe_freeze,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [1:0]       fwd_c,
  output logic [CNT_W-1:0] stall_count
);

  localparam logic [REG_W-1:0] PC_IDX = REG_W'(PC_REG);

  hz_state_t        state;
  hz_state_t        state_next;
  logic [REG_W-1:0] src [3];
  logic [1:0]       sel [3];
  logic [2:0]       ex_hit;
  logic             ex_fwd_ok;
  logic             load_use;

  assign src[0] = id_rn;
  assign src[1] = id_rm;
  assign src[2] = id_rs;

  // A load's data is not available in EX, so EX forwarding excludes loads.
  assign ex_fwd_ok = ex_reg_write && !ex_mem_read;

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_operand
      assign ex_hit[gi] = id_use[gi] && (src[gi] == ex_rd) && (src[gi] != PC_IDX);

      arm_fwd_select #(.REG_W(REG_W)) u_fwd (
        .src           (src[gi]),
        .used          (id_use[gi]),
        .ex_rd         (ex_rd),
        .ex_fwd_ok     (ex_fwd_ok),
        .mem_rd        (mem_rd),
        .mem_reg_write (mem_reg_write),
        .wb_rd         (wb_rd),
        .wb_reg_write  (wb_reg_write),
        .sel           (sel[gi])
      );
    end
  endgenerate

  assign load_use = ex_mem_read && ex_reg_write && (|ex_hit);

  // Forwarding selects track inputs even while frozen; forced to RF in reset.
  assign fwd_a = rst_n ? sel[0] : FWD_RF;
  assign fwd_b = rst_n ? sel[1] : FWD_RF;
  assign fwd_c = rst_n ? sel[2] : FWD_RF;

  // State register; reset returns the sequencer to RUN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
    end else begin
      state <= state_next;
    end
  end

  // Next state and pipeline controls. MEM_WAIT releases by evaluating as RUN
  // in the same cycle; LD_STALL masks load_use because EX holds the bubble.
  always_comb begin
    pc_enable    = 1'b1;
    if_id_enable = 1'b1;
    if_id_flush  = 1'b0;
    nop_insert   = 1'b0;
    pipe_freeze  = 1'b0;
    state_next   = RUN;
    if (!rst_n) begin
      pc_enable    = 1'b0;
      if_id_enable = 1'b0;
      nop_insert   = 1'b1;
      pipe_freeze  = 1'b1;
    end else if (mem_busy) begin
      pc_enable    = 1'b0;
      if_id_enable = 1'b0;
      pipe_freeze  = 1'b1;
      state_next   = MEM_WAIT;
    end else if (ex_branch_taken) begin
      if_id_flush  = 1'b1;
      nop_insert   = 1'b1;
    end else if (load_use && (state != LD_STALL)) begin
      pc_enable    = 1'b0;
      if_id_enable = 1'b0;
      nop_insert   = 1'b1;
      state_next   = LD_STALL;
    end
  end

  // Saturating count of cycles in which the PC did not advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_count <= '0;
    end else if (!pc_enable && (stall_count != {CNT_W{1'b1}})) begin
      stall_count <= stall_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_arm_hazard_controller.sv
// Self-checking bench for arm_hazard_controller: directed table, hand-written
// multi-cycle sequences and a randomized run against a rule-level model.
module tb_arm_hazard_controller;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] id_rn, id_rm, id_rs, ex_rd, mem_rd, wb_rd;
  logic [2:0] id_use;
  logic       ex_reg_write, ex_mem_read, mem_reg_write, wb_reg_write;
  logic       ex_branch_taken, mem_busy;
  logic       pc_enable, if_id_enable, if_id_flush, nop_insert, pipe_freeze;
  logic [1:0] fwd_a, fwd_b, fwd_c;
  logic [15:0] stall_count;
  logic       s_pc, s_ifid, s_flush, s_nop, s_freeze;
  logic [1:0] s_fa, s_fb, s_fc;
  logic [3:0] s_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  arm_hazard_controller dut (
    .clk(clk), .rst_n(rst_n), .id_rn(id_rn), .id_rm(id_rm), .id_rs(id_rs),
    .id_use(id_use), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read), .mem_rd(mem_rd), .mem_reg_write(mem_reg_write),
    .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .ex_branch_taken(ex_branch_taken),
    .mem_busy(mem_busy), .pc_enable(pc_enable), .if_id_enable(if_id_enable),
    .if_id_flush(if_id_flush), .nop_insert(nop_insert), .pipe_freeze(pipe_freeze),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .fwd_c(fwd_c), .stall_count(stall_count)
  );

  arm_hazard_controller #(.REG_W(4), .CNT_W(4)) dut_sat (
    .clk(clk), .rst_n(rst_n), .id_rn(id_rn), .id_rm(id_rm), .id_rs(id_rs),
    .id_use(id_use), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read), .mem_rd(mem_rd), .mem_reg_write(mem_reg_write),
    .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .ex_branch_taken(ex_branch_taken),
    .mem_busy(mem_busy), .pc_enable(s_pc), .if_id_enable(s_ifid),
    .if_id_flush(s_flush), .nop_insert(s_nop), .pipe_freeze(s_freeze),
    .fwd_a(s_fa), .fwd_b(s_fb), .fwd_c(s_fc), .stall_count(s_count)
  );

  typedef struct {
    int rn, rm, rs, use_bits, ex_rd, exw, exr, mem_rd, memw, wb_rd, wbw, br, busy;
    int pc, ifid, flush, nop, freeze, fa, fb, fc;
  } vec_t;

  typedef struct {
    int pc, ifid, flush, nop, freeze, fa, fb, fc;
  } exp_t;

  vec_t vecs[15];

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] req);
    checks++;
    if (actual !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, actual, req);
    end
  endtask

  task automatic check_outs(input string tag, input exp_t e);
    check({tag, ".pc_enable"},    32'(pc_enable),    32'(e.pc));
    check({tag, ".if_id_enable"}, 32'(if_id_enable), 32'(e.ifid));
    check({tag, ".if_id_flush"},  32'(if_id_flush),  32'(e.flush));
    check({tag, ".nop_insert"},   32'(nop_insert),   32'(e.nop));
    check({tag, ".pipe_freeze"},  32'(pipe_freeze),  32'(e.freeze));
    check({tag, ".fwd_a"},        32'(fwd_a),        32'(e.fa));
    check({tag, ".fwd_b"},        32'(fwd_b),        32'(e.fb));
    check({tag, ".fwd_c"},        32'(fwd_c),        32'(e.fc));
  endtask

  task automatic idle();
    id_rn = 0; id_rm = 0; id_rs = 0; id_use = 0;
    ex_rd = 0; ex_reg_write = 0; ex_mem_read = 0;
    mem_rd = 0; mem_reg_write = 0; wb_rd = 0; wb_reg_write = 0;
    ex_branch_taken = 0; mem_busy = 0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    next_cycle();
    rst_n = 1'b0;
    idle();
    next_cycle();
    rst_n = 1'b1;
  endtask

  // Which stage supplies an operand: the youngest writer whose data exists.
  function automatic int fwd_model(input int src, input bit used);
    if (!used || src == 15) return 0;
    if (ex_reg_write && !ex_mem_read && int'(ex_rd) == src) return 1;
    if (mem_reg_write && int'(mem_rd) == src) return 2;
    if (wb_reg_write && int'(wb_rd) == src) return 3;
    return 0;
  endfunction

  // Expected controls from the priority rules: memory wait, then branch,
  // then an unmasked load-use hazard on any used non-PC source.
  function automatic exp_t model(input bit masked);
    exp_t e;
    int srcs[3];
    bit hazard = 0;
    srcs[0] = int'(id_rn); srcs[1] = int'(id_rm); srcs[2] = int'(id_rs);
    foreach (srcs[i])
      if (id_use[i] && srcs[i] != 15 && srcs[i] == int'(ex_rd)) hazard = 1;
    hazard = hazard && ex_mem_read && ex_reg_write && !masked;
    e = '{1, 1, 0, 0, 0, 0, 0, 0};
    if (mem_busy) e = '{0, 0, 0, 0, 1, 0, 0, 0};
    else if (ex_branch_taken) e = '{1, 1, 1, 1, 0, 0, 0, 0};
    else if (hazard) e = '{0, 0, 0, 1, 0, 0, 0, 0};
    e.fa = fwd_model(srcs[0], id_use[0]);
    e.fb = fwd_model(srcs[1], id_use[1]);
    e.fc = fwd_model(srcs[2], id_use[2]);
    return e;
  endfunction

  function automatic logic [3:0] rreg();
    return ($urandom_range(0, 7) == 0) ? 4'hF : 4'($urandom_range(0, 6));
  endfunction

  initial begin
    exp_t e;
    bit   masked;
    int   mcount;

    vecs[0]  = '{0,0,0,0, 0,0,0, 0,0, 0,0, 0,0,   1,1,0,0,0, 0,0,0};
    vecs[1]  = '{2,0,0,1, 2,1,0, 0,0, 0,0, 0,0,   1,1,0,0,0, 1,0,0};
    vecs[2]  = '{4,0,0,1, 4,1,1, 0,0, 0,0, 0,0,   0,0,0,1,0, 0,0,0};
    vecs[3]  = '{15,0,0,1, 15,1,1, 0,0, 0,0, 0,0, 1,1,0,0,0, 0,0,0};
    vecs[4]  = '{4,0,0,0, 4,1,1, 0,0, 0,0, 0,0,   1,1,0,0,0, 0,0,0};
    vecs[5]  = '{0,0,6,4, 6,1,1, 0,0, 0,0, 0,0,   0,0,0,1,0, 0,0,0};
    vecs[6]  = '{0,3,0,2, 3,1,1, 0,0, 0,0, 1,0,   1,1,1,1,0, 0,0,0};
    vecs[7]  = '{0,0,0,0, 0,0,0, 0,0, 0,0, 1,1,   0,0,0,0,1, 0,0,0};
    vecs[8]  = '{0,7,0,2, 0,0,0, 7,1, 0,0, 0,0,   1,1,0,0,0, 0,2,0};
    vecs[9]  = '{0,0,9,4, 0,0,0, 0,0, 9,1, 0,0,   1,1,0,0,0, 0,0,3};
    vecs[10] = '{1,0,0,1, 0,0,0, 1,1, 1,1, 0,0,   1,1,0,0,0, 2,0,0};
    vecs[11] = '{3,0,0,1, 3,0,0, 0,0, 0,0, 0,0,   1,1,0,0,0, 0,0,0};
    vecs[12] = '{2,0,0,1, 2,1,0, 0,0, 0,0, 0,1,   0,0,0,0,1, 1,0,0};
    vecs[13] = '{4,0,0,1, 4,0,1, 0,0, 0,0, 0,0,   1,1,0,0,0, 0,0,0};
    vecs[14] = '{8,8,8,7, 8,1,0, 8,1, 8,1, 0,0,   1,1,0,0,0, 1,1,1};

    // Reset values while held in reset, even with forwardable inputs present.
    idle();
    id_rn = 5; id_use = 3'b001; ex_rd = 5; ex_reg_write = 1;
    #2;
    check_outs("reset", '{0, 0, 0, 1, 1, 0, 0, 0});
    check("reset.stall_count", 32'(stall_count), 0);
    do_reset();

    // Directed table, each vector applied from the RUN state.
    foreach (vecs[i]) begin
      next_cycle();
      idle();
      next_cycle();
      id_rn = 4'(vecs[i].rn); id_rm = 4'(vecs[i].rm); id_rs = 4'(vecs[i].rs);
      id_use = 3'(vecs[i].use_bits);
      ex_rd = 4'(vecs[i].ex_rd); ex_reg_write = 1'(vecs[i].exw); ex_mem_read = 1'(vecs[i].exr);
      mem_rd = 4'(vecs[i].mem_rd); mem_reg_write = 1'(vecs[i].memw);
      wb_rd = 4'(vecs[i].wb_rd); wb_reg_write = 1'(vecs[i].wbw);
      ex_branch_taken = 1'(vecs[i].br); mem_busy = 1'(vecs[i].busy);
      @(negedge clk);
      check_outs($sformatf("vec%0d", i), '{vecs[i].pc, vecs[i].ifid, vecs[i].flush,
                 vecs[i].nop, vecs[i].freeze, vecs[i].fa, vecs[i].fb, vecs[i].fc});
    end

    // Memory wait of four cycles, then release with no bubble.
    do_reset();
    next_cycle();
    mem_busy = 1;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) next_cycle();
      @(negedge clk);
      check_outs($sformatf("busy%0d", k), '{0, 0, 0, 0, 1, 0, 0, 0});
    end
    next_cycle();
    mem_busy = 0;
    @(negedge clk);
    check_outs("busy_release", '{1, 1, 0, 0, 0, 0, 0, 0});
    check("busy_count", 32'(stall_count), 4);

    // LDR r3 then a consumer of r3 in rm.
    next_cycle();
    ex_mem_read = 1; ex_reg_write = 1; ex_rd = 3; id_rm = 3; id_use = 3'b010;
    @(negedge clk);
    check_outs("ldr_stall", '{0, 0, 0, 1, 0, 0, 0, 0});
    next_cycle();
    @(negedge clk);
    check_outs("ldr_masked", '{1, 1, 0, 0, 0, 0, 0, 0});
    next_cycle();
    ex_mem_read = 0; ex_reg_write = 0; ex_rd = 0; mem_rd = 3; mem_reg_write = 1;
    @(negedge clk);
    check_outs("ldr_mem_fwd", '{1, 1, 0, 0, 0, 0, 2, 0});
    check("ldr_count", 32'(stall_count), 5);

    // Branch wins over load-use and does not enter LD_STALL.
    next_cycle();
    idle();
    ex_mem_read = 1; ex_reg_write = 1; ex_rd = 3; id_rm = 3; id_use = 3'b010;
    ex_branch_taken = 1;
    @(negedge clk);
    check_outs("br_over_ld", '{1, 1, 1, 1, 0, 0, 0, 0});
    next_cycle();
    ex_branch_taken = 0;
    @(negedge clk);
    check_outs("br_then_ld", '{0, 0, 0, 1, 0, 0, 0, 0});

    // Branch held during a freeze is acted on in the release cycle.
    next_cycle();
    idle();
    mem_busy = 1; ex_branch_taken = 1;
    next_cycle();
    @(negedge clk);
    check_outs("br_frozen", '{0, 0, 0, 0, 1, 0, 0, 0});
    next_cycle();
    mem_busy = 0;
    @(negedge clk);
    check_outs("br_release", '{1, 1, 1, 1, 0, 0, 0, 0});

    // Forwarding priority for rn=5.
    next_cycle();
    idle();
    id_rn = 5; id_use = 3'b001; ex_rd = 5; ex_reg_write = 1;
    mem_rd = 5; mem_reg_write = 1; wb_rd = 5; wb_reg_write = 1;
    @(negedge clk);
    check("fwd_ex", 32'(fwd_a), 1);
    next_cycle();
    ex_reg_write = 0;
    @(negedge clk);
    check("fwd_mem", 32'(fwd_a), 2);
    next_cycle();
    id_rn = 15; ex_rd = 15; mem_rd = 15; wb_rd = 15; ex_reg_write = 1;
    @(negedge clk);
    check("fwd_pc", 32'(fwd_a), 0);

    // Randomized run against the rule model.
    do_reset();
    masked = 0;
    mcount = 0;
    for (int n = 0; n < 400; n++) begin
      next_cycle();
      id_rn = rreg(); id_rm = rreg(); id_rs = rreg(); id_use = 3'($urandom_range(0, 7));
      ex_rd = rreg(); ex_reg_write = 1'($urandom_range(0, 1)); ex_mem_read = 1'($urandom_range(0, 1));
      mem_rd = rreg(); mem_reg_write = 1'($urandom_range(0, 1));
      wb_rd = rreg(); wb_reg_write = 1'($urandom_range(0, 1));
      ex_branch_taken = ($urandom_range(0, 6) == 0);
      mem_busy = ($urandom_range(0, 4) == 0);
      @(negedge clk);
      e = model(masked);
      check_outs($sformatf("rnd%0d", n), e);
      check($sformatf("rnd%0d.stall_count", n), 32'(stall_count), 32'(mcount));
      check($sformatf("rnd%0d.sat_count", n), 32'(s_count), 32'((mcount > 15) ? 15 : mcount));
      masked = (e.pc == 0) && !mem_busy;
      if (e.pc == 0) mcount++;
    end

    // Reset arriving mid-MEM_WAIT with 37 stall cycles counted.
    do_reset();
    next_cycle();
    mem_busy = 1;
    repeat (37) next_cycle();
    check("mw_count37", 32'(stall_count), 37);
    #2;
    rst_n = 1'b0;
    #1;
    check_outs("mw_reset", '{0, 0, 0, 1, 1, 0, 0, 0});
    check("mw_reset_count", 32'(stall_count), 0);
    next_cycle();
    rst_n = 1'b1;
    mem_busy = 0;
    @(negedge clk);
    check_outs("mw_run", '{1, 1, 0, 0, 0, 0, 0, 0});
    check("mw_run_count", 32'(stall_count), 0);

    // Narrow counter saturates at 15 while the wide one keeps counting.
    next_cycle();
    mem_busy = 1;
    repeat (14) next_cycle();
    check("sat14", 32'(s_count), 14);
    repeat (6) next_cycle();
    check("sat15", 32'(s_count), 15);
    check("wide20", 32'(stall_count), 20);
    next_cycle();
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
